// File: rtl/inv_key_sched_if.sv
// rtl/inv_key_sched_if.sv - load/status and round-key stream bundle for inv_key_sched
//
// Purpose: groups the key-load request and the round-key valid/ready stream.
// Signals:
//   start     load request (sampled by the schedule only when idle)
//   key_in    128-bit key, w0 = key_in[127:96] .. w3 = key_in[31:0]
//   busy      schedule is working on a key
//   rk_valid  rk_data/rk_round/rk_last are valid
//   rk_ready  consumer accepts the beat
//   rk_data   128-bit round key, same word order as key_in
//   rk_round  round index of rk_data (10 down to 0)
//   rk_last   marks the round-0 beat
// Modports: master = key source / key consumer, slave = the schedule.

interface inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_round, rk_last
  );
endinterface

// File: rtl/inv_key_sched.sv
// rtl/inv_key_sched.sv - sequential AES-128 inverse key schedule, round keys 10 down to 0
//
// Purpose: loads either the cipher key (forward-expanded to round 10 first) or the
// round-10 key, then streams round keys in reverse order over a valid/ready handshake.
// A single round of key-expansion logic (one shared g() with four S-boxes) is reused
// for both the forward and the inverse step.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   ks_io  inv_key_sched_if.slave: start/key_in/busy and the rk_* round-key stream

module inv_key_sched #(
  parameter bit KEY_IS_CIPHER = 1'b1,
  parameter int NR            = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  inv_key_sched_if.slave   ks_io
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  // AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, FWD, REV} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;

  // Byte b lives at bit offset (255-b)*8, and 255-b == ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] ofs;
    ofs = {~b, 3'b000};
    return SBOX[ofs +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [31:0]  w_a, w_b, w_c, w_d;
  logic [31:0]  inv_d;
  logic [31:0]  g_in, g_rot, g_out;
  logic [31:0]  fa, fb, fc, fd;
  logic [127:0] fwd_key, inv_key;

  assign w_a = key_q[127:96];
  assign w_b = key_q[95:64];
  assign w_c = key_q[63:32];
  assign w_d = key_q[31:0];

  // The inverse step needs g() of the already-recovered last word, the forward
  // step needs g() of the current last word; one g() serves both.
  assign inv_d = w_d ^ w_c;
  assign g_in  = (state_q == FWD) ? w_d : inv_d;
  assign g_rot = {g_in[23:0], g_in[31:24]};
  assign g_out = {sbox(g_rot[31:24]), sbox(g_rot[23:16]),
                  sbox(g_rot[15:8]),  sbox(g_rot[7:0])} ^ {rcon(cnt_q), 24'h000000};

  assign fa = w_a ^ g_out;
  assign fb = w_b ^ fa;
  assign fc = w_c ^ fb;
  assign fd = w_d ^ fc;
  assign fwd_key = {fa, fb, fc, fd};
  assign inv_key = {w_a ^ g_out, w_b ^ w_a, w_c ^ w_b, inv_d};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (ks_io.start) begin
          key_d = ks_io.key_in;
          if (KEY_IS_CIPHER) begin
            state_d = FWD;
            cnt_d   = 4'd1;
          end else begin
            state_d = REV;
            cnt_d   = LAST_RND;
          end
        end
      end
      FWD: begin
        key_d = fwd_key;
        if (cnt_q == LAST_RND) begin
          state_d = REV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      REV: begin
        if (ks_io.rk_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d = inv_key;
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Stream outputs are zero outside REV so the forward-expansion intermediates
  // never appear on the bus.
  logic rev;
  assign rev            = (state_q == REV);
  assign ks_io.busy     = (state_q != IDLE);
  assign ks_io.rk_valid = rev;
  assign ks_io.rk_data  = rev ? key_q : '0;
  assign ks_io.rk_round = rev ? cnt_q : 4'd0;
  assign ks_io.rk_last  = rev && (cnt_q == 4'd0);

endmodule

// File: tb/tb_inv_key_sched.sv
// tb/tb_inv_key_sched.sv - directed-vector bench for inv_key_sched (both key modes)

module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rdy;
  logic         start0, start1;
  logic [127:0] key0, key1;
  int           n_vec  = 0;
  int           n_miss = 0;
  bit           cur;

  always #5 clk = ~clk;

  inv_key_sched_if if0 ();
  inv_key_sched_if if1 ();

  assign if0.start    = start0;
  assign if0.key_in   = key0;
  assign if0.rk_ready = rdy;
  assign if1.start    = start1;
  assign if1.key_in   = key1;
  assign if1.rk_ready = rdy;

  inv_key_sched #(.KEY_IS_CIPHER(1'b0), .NR(10)) u_dut0 (.clk(clk), .rst_n(rst_n), .ks_io(if0));
  inv_key_sched #(.KEY_IS_CIPHER(1'b1), .NR(10)) u_dut1 (.clk(clk), .rst_n(rst_n), .ks_io(if1));

  wire          val_w  = cur ? if1.rk_valid : if0.rk_valid;
  wire          busy_w = cur ? if1.busy     : if0.busy;
  wire [127:0]  dat_w  = cur ? if1.rk_data  : if0.rk_data;
  wire [3:0]    rnd_w  = cur ? if1.rk_round : if0.rk_round;
  wire          last_w = cur ? if1.rk_last  : if0.rk_last;

  // Round keys indexed by round number.
  logic [127:0] exp0 [11];
  logic [127:0] exp1 [11];

  localparam logic [127:0] K_R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke_start(input bit sel);
    if (sel) begin
      start1 = 1'b1;
      key1   = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      start0 = 1'b1;
      key0   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Issue start, check latency, then take nb beats with optional ready stalls
  // and optional start pokes while busy.
  task automatic do_stream(input bit sel, input logic [127:0] key, input bit stall,
                           input bit poke, input int nb);
    int           lat, idx, cyc;
    bit           held;
    logic [127:0] hd, e;
    logic [3:0]   hr;
    logic         hl;
    cur = sel;
    rdy = 1'b0;
    if (sel) begin key1 = key; start1 = 1'b1; end
    else     begin key0 = key; start0 = 1'b1; end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_start", {127'd0, busy_w}, 128'd1);
    lat = 1;
    while (!val_w && lat < 40) begin
      if (poke) poke_start(sel);
      tick();
      lat++;
    end
    chk("first_valid_latency", 128'(lat), sel ? 128'd11 : 128'd1);
    idx  = 0;
    cyc  = 0;
    held = 1'b0;
    hd = '0; hr = '0; hl = 1'b0;
    while (idx < nb && cyc < 400) begin
      if (val_w) begin
        e = sel ? exp1[10-idx] : exp0[10-idx];
        chk("rk_data", dat_w, e);
        chk("rk_round", {124'd0, rnd_w}, 128'(10 - idx));
        chk("rk_last", {127'd0, last_w}, {127'd0, idx == 10});
        if (held) begin
          chk("stall_hold_data", dat_w, hd);
          chk("stall_hold_round", {124'd0, rnd_w}, {124'd0, hr});
          chk("stall_hold_last", {127'd0, last_w}, {127'd0, hl});
        end
        rdy  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        hd   = dat_w;
        hr   = rnd_w;
        hl   = last_w;
        held = !rdy;
        if (rdy) idx++;
      end else begin
        chk("rk_valid_in_stream", {127'd0, val_w}, 128'd1);
        rdy = 1'b0;
      end
      if (poke) poke_start(sel);
      tick();
      cyc++;
    end
    rdy    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("beats_taken", 128'(idx), 128'(nb));
    if (nb == 11) begin
      chk("busy_after_last", {127'd0, busy_w}, 128'd0);
      chk("valid_after_last", {127'd0, val_w}, 128'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {127'd0, val_w}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy_w}, 128'd0);
    chk({tag, "_data"}, dat_w, 128'd0);
    chk({tag, "_round"}, {124'd0, rnd_w}, 128'd0);
    chk({tag, "_last"}, {127'd0, last_w}, 128'd0);
  endtask

  initial begin
    exp0[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    exp0[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    exp0[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    exp0[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    exp0[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    exp0[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    exp0[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    exp0[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    exp0[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    exp0[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    exp0[10] = K_R10;
    exp1[0]  = K_CIPHER;
    exp1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n  = 1'b0;
    rdy    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    key0   = '0;
    key1   = '0;
    cur    = 1'b0;
    repeat (3) tick();
    cur = 1'b0; chk_zero("reset0");
    cur = 1'b1; chk_zero("reset1");
    rst_n = 1'b1;
    tick();

    // T1: round-10 key in, zero-wait consumer
    do_stream(1'b0, K_R10, 1'b0, 1'b0, 11);
    tick();
    // T2: cipher key in
    do_stream(1'b1, K_CIPHER, 1'b0, 1'b0, 11);
    tick();
    // T3: random backpressure
    do_stream(1'b1, K_CIPHER, 1'b1, 1'b0, 11);
    tick();
    // T4: start hammered while busy, including on the round-0 accept edge
    do_stream(1'b1, K_CIPHER, 1'b0, 1'b1, 11);
    repeat (2) begin
      tick();
      chk("no_restart_busy", {127'd0, busy_w}, 128'd0);
    end

    // T5: asynchronous reset mid-stream, then a clean replay
    do_stream(1'b0, K_R10, 1'b0, 1'b0, 5);
    cur = 1'b0;
    chk("pre_reset_valid", {127'd0, val_w}, 128'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    tick();
    chk_zero("held_reset");
    rst_n = 1'b1;
    tick();
    do_stream(1'b0, K_R10, 1'b0, 1'b0, 11);

    // T6: restart one cycle after the round-0 accept
    tick();
    do_stream(1'b1, K_CIPHER, 1'b0, 1'b0, 11);
    do_stream(1'b1, K_CIPHER, 1'b0, 1'b0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
